// File: rtl/combo_lock_pkg.sv
// Shared state encoding and width helpers for the combination lock.
package combo_lock_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        PROGRAM  = 2'd2,
        LOCKOUT  = 2'd3
    } state_t;

    function automatic int pos_w(input int code_len);
        return (code_len > 1) ? $clog2(code_len) : 1;
    endfunction

    // Tries only ever needs to hold 0..MAX_TRIES-1, sized to MAX_TRIES for headroom.
    function automatic int tries_w(input int max_tries);
        return (max_tries > 1) ? $clog2(max_tries + 1) : 1;
    endfunction

    function automatic int timer_w(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/lockout_timer.sv
// Loadable down-counter; o_done is high during the cycle whose edge takes the count 1->0.
module lockout_timer
    import combo_lock_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    output logic o_done
);

    localparam int TW = timer_w(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] LOAD_VAL = TW'(LOCKOUT_CYCLES);
    localparam logic [TW-1:0] ONE      = TW'(1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    assign o_done = (r_cnt == ONE);

endmodule

// File: rtl/combo_lock_seq.sv
// Sequential combination lock with wrong-attempt lockout and atomic code reprogramming.
module combo_lock_seq
    import combo_lock_pkg::*;
#(
    parameter int DIGIT_W        = 3,
    parameter int CODE_LEN       = 4,
    parameter int MAX_TRIES      = 3,
    parameter int LOCKOUT_CYCLES = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [DIGIT_W-1:0]         digit_in,
    input  logic                       digit_valid,
    input  logic                       prog,
    input  logic                       relock,
    output logic                       locked,
    output logic                       unlocked,
    output logic                       lockout,
    output logic                       programming,
    output logic                       fail,
    output logic [pos_w(CODE_LEN)-1:0] entry_pos
);

    localparam int POS_W   = pos_w(CODE_LEN);
    localparam int TRIES_W = tries_w(MAX_TRIES);
    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(CODE_LEN - 1);
    localparam logic [POS_W-1:0]   POS_ONE    = POS_W'(1);
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES - 1);
    localparam logic [TRIES_W-1:0] TRIES_ONE  = TRIES_W'(1);

    state_t               r_state, w_state_nx;
    logic [POS_W-1:0]     r_pos, w_pos_nx;
    logic                 r_mis, w_mis_nx;
    logic [TRIES_W-1:0]   r_tries, w_tries_nx;
    logic                 r_fail, w_fail_nx;
    logic [DIGIT_W-1:0]   r_code   [CODE_LEN];
    logic [DIGIT_W-1:0]   r_shadow [CODE_LEN];
    logic                 w_load, w_shadow_we, w_commit, w_timer_done;
    logic                 w_last, w_mis_any;

    lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_load(w_load),
        .o_done(w_timer_done)
    );

    always_comb begin
        w_state_nx  = r_state;
        w_pos_nx    = r_pos;
        w_mis_nx    = r_mis;
        w_tries_nx  = r_tries;
        w_fail_nx   = 1'b0;
        w_load      = 1'b0;
        w_shadow_we = 1'b0;
        w_commit    = 1'b0;
        w_last      = (r_pos == POS_LAST);
        w_mis_any   = r_mis | (digit_in != r_code[r_pos]);
        case (r_state)
            LOCKED: begin
                if (relock) begin
                    w_pos_nx = '0;
                    w_mis_nx = 1'b0;
                end else if (digit_valid) begin
                    if (w_last) begin
                        w_pos_nx = '0;
                        w_mis_nx = 1'b0;
                        if (!w_mis_any) begin
                            w_state_nx = UNLOCKED;
                            w_tries_nx = '0;
                        end else begin
                            w_fail_nx = 1'b1;
                            if (r_tries == TRIES_LAST) begin
                                w_state_nx = LOCKOUT;
                                w_load     = 1'b1;
                                w_tries_nx = '0;
                            end else begin
                                w_tries_nx = r_tries + TRIES_ONE;
                            end
                        end
                    end else begin
                        w_pos_nx = r_pos + POS_ONE;
                        w_mis_nx = w_mis_any;
                    end
                end
            end
            UNLOCKED: begin
                if (relock) begin
                    w_state_nx = LOCKED;
                end else if (prog) begin
                    w_state_nx = PROGRAM;
                    w_pos_nx   = '0;
                end
            end
            PROGRAM: begin
                if (relock) begin
                    w_state_nx = LOCKED;
                    w_pos_nx   = '0;
                end else if (!prog) begin
                    w_state_nx = UNLOCKED;
                    w_pos_nx   = '0;
                end else if (digit_valid) begin
                    w_shadow_we = 1'b1;
                    if (w_last) begin
                        w_commit   = 1'b1;
                        w_state_nx = LOCKED;
                        w_pos_nx   = '0;
                    end else begin
                        w_pos_nx = r_pos + POS_ONE;
                    end
                end
            end
            LOCKOUT: begin
                if (w_timer_done) begin
                    w_state_nx = LOCKED;
                end
            end
            default: w_state_nx = LOCKED;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LOCKED;
            r_pos   <= '0;
            r_mis   <= 1'b0;
            r_tries <= '0;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_pos   <= w_pos_nx;
            r_mis   <= w_mis_nx;
            r_tries <= w_tries_nx;
            r_fail  <= w_fail_nx;
        end
    end

    // The final digit bypasses the shadow so the whole code lands in a single edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CODE_LEN; i++) begin
                r_code[i]   <= '0;
                r_shadow[i] <= '0;
            end
        end else begin
            if (w_shadow_we) begin
                r_shadow[r_pos] <= digit_in;
            end
            if (w_commit) begin
                for (int i = 0; i < CODE_LEN; i++) begin
                    r_code[i] <= (i == CODE_LEN - 1) ? digit_in : r_shadow[i];
                end
            end
        end
    end

    assign locked      = (r_state == LOCKED);
    assign unlocked    = (r_state == UNLOCKED);
    assign lockout     = (r_state == LOCKOUT);
    assign programming = (r_state == PROGRAM);
    assign fail        = r_fail;
    assign entry_pos   = r_pos;

endmodule

// File: doc/combo_lock_seq.md
# combo_lock_seq

Parametrised sequential combination lock: accepts a stream of strobed digits, compares them against a stored multi-digit code and drives locked/unlocked status. It adds wrong-attempt counting with a timed lockout. The code can be reprogrammed only while unlocked, through an atomic shadow buffer. It sits behind the I/O wrapper that maps pins to digit, strobe and command inputs, and drives status LEDs.

## Interface
Parameters:
- DIGIT_W, 3, width of one code digit
- CODE_LEN, 4, digits per code (≥1)
- MAX_TRIES, 3, consecutive failed entries before lockout (≥1)
- LOCKOUT_CYCLES, 16, clock cycles spent in lockout (≥1)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- digit_in  in  DIGIT_W  digit value, sampled when digit_valid=1
- digit_valid  in  1  one-cycle digit strobe; each high cycle is one digit
- prog  in  1  program-mode request (level)
- relock  in  1  relock / clear-entry command (level, sampled per cycle)
- locked  out  1  state is LOCKED
- unlocked  out  1  state is UNLOCKED
- lockout  out  1  state is LOCKOUT
- programming  out  1  state is PROGRAM
- fail  out  1  one-cycle pulse on a completed wrong entry
- entry_pos  out  max(1,$clog2(CODE_LEN))  digits accepted in current entry/program sequence

## Operation
- Reset: state LOCKED; code and shadow all-zero; pos=0, mismatch=0, tries=0, lockout timer=0. Outputs: locked=1, others 0, entry_pos=0.
- LOCKED: on digit_valid, mismatch |= (digit_in != code[pos]), pos++. On the CODE_LEN-th digit, pos→0 and mismatch→0, and:
  - if no mismatch over the whole entry → UNLOCKED, tries=0;
  - else fail pulses and tries++; if tries reaches MAX_TRIES → LOCKOUT, timer loaded with LOCKOUT_CYCLES, tries=0; otherwise stay LOCKED.
- LOCKED with relock=1: pos=0, mismatch=0; tries unchanged; partial entry discarded.
- UNLOCKED:
  - relock=1 → LOCKED.
  - else prog=1 → PROGRAM, pos=0.
  - digit_valid ignored.
- PROGRAM: on digit_valid, shadow[pos]=digit_in, pos++. On the CODE_LEN-th digit, code←shadow in one cycle (atomic) and state → LOCKED, pos=0.
  - prog deasserted before completion → UNLOCKED, shadow discarded, code unchanged.
  - relock=1 → LOCKED, code unchanged.
- LOCKOUT: timer decrements each cycle; at 1→0 → LOCKED. digit_valid, prog and relock are all ignored.
- Priority per cycle: relock > prog > digit_valid. A digit arriving in the same cycle as relock is dropped.
- Width rules:
  - pos wraps only by explicit clear at CODE_LEN-1; never free-runs.
  - tries saturates at MAX_TRIES and is never observable above it.

## Timing
- All outputs registered; each reflects the state from the edge that sampled the causing input, i.e. visible one cycle after the strobe cycle.
- Correct last digit sampled at edge N → unlocked=1 and locked=0 from edge N onward.
- fail is high for exactly one cycle, coincident with the state update of the failing last digit.
- lockout is high for exactly LOCKOUT_CYCLES cycles; locked reasserts on the following cycle.
- Back-to-back digit_valid on consecutive cycles is fully supported; no throughput gaps.
- rst_n assertion mid-entry, mid-program or mid-lockout returns every register to its reset value immediately (asynchronous). A partially programmed code is never committed.

## Structure
- Package combo_lock_pkg holds:
  - state enum typedef (LOCKED, UNLOCKED, PROGRAM, LOCKOUT);
  - width helper functions for pos, tries and timer.
- Sub-module lockout_timer: loadable down-counter with a done pulse, parametrised by LOCKOUT_CYCLES.
- Code and shadow are CODE_LEN×DIGIT_W register arrays inside the top level.

## Test plan
Defaults: DIGIT_W=3, CODE_LEN=4, MAX_TRIES=3, LOCKOUT_CYCLES=16.
- Reset → enter 0,0,0,0 → unlocked=1 one cycle after 4th strobe; fail never pulses.
- From UNLOCKED: prog=1, enter 5,3,7,1 → programming=1 during entry, locked=1 after 4th. Then enter 5,3,7,1 → unlocked. Enter 5,3,7,2 instead → fail pulse, stays locked.
- Three wrong 4-digit entries → fail pulses 3×, then lockout=1 for exactly 16 cycles. Digits sent during lockout are ignored; afterwards correct code unlocks.
- Program 1,2 then drop prog → UNLOCKED, old code still valid. Relock then enter old code → unlocks.
- Enter 5,3 then relock in same cycle as a digit strobe → entry_pos=0; fresh 5,3,7,1 unlocks.
- rst_n low for one cycle mid-lockout and mid-program → locked=1, code back to 0,0,0,0, tries=0.
